// File: rtl/aes_pkg.sv
// aes_pkg: shared FSM type, constants and GF(2^8) helpers for the AES-128 round engine.
package aes_pkg;

  localparam int unsigned AES_NUM_ROUNDS = 10;
  localparam int unsigned BLOCK_W        = 128;
  localparam logic [7:0]  RCON_INIT      = 8'h01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[11'd2040 - {b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; byte a0 sits in bits [31:24].
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: derives the next AES-128 round key from the current one and rcon.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] rk,
  input  logic [7:0]         rcon,
  output logic [BLOCK_W-1:0] rk_next
);

  logic [31:0] w0, w1, w2, w3, temp, n0, n1, n2, n3;

  assign w0 = rk[127:96];
  assign w1 = rk[95:64];
  assign w2 = rk[63:32];
  assign w3 = rk[31:0];

  // SubWord(RotWord(w3)) with rcon folded into the leading byte.
  assign temp = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};

  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rk_next = {n0, n1, n2, n3};

endmodule

// File: rtl/sub_bytes.sv
// sub_bytes: byte-wise S-box substitution of a 128-bit AES state.
module sub_bytes
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state,
  output logic [BLOCK_W-1:0] result
);

  // One S-box lookup per state byte.
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign result[8*i +: 8] = sbox(state[8*i +: 8]);
  end

endmodule

// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES-128 encryptor, one round per clock with on-the-fly key expansion.
// Optional feature macro AES_ABORT_EN adds an 'abort' input that drops an in-flight block.
module aes_round_engine
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic               clk,
  input  logic               rst,
`ifdef AES_ABORT_EN
  input  logic               abort,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] data_in,
  input  logic [BLOCK_W-1:0] key_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] data_out
);

  aes_state_e         fsm;
  logic               ready_q;
  logic [BLOCK_W-1:0] state_q;
  logic [BLOCK_W-1:0] rk_q;
  logic [7:0]         rcon_q;
  logic [3:0]         round_q;

  logic [BLOCK_W-1:0] subbed, shifted, mixed, rk_next, round_out;
  logic               accept;

  sub_bytes u_sub_bytes (
    .state  (state_q),
    .result (subbed)
  );

  aes_key_step u_key_step (
    .rk      (rk_q),
    .rcon    (rcon_q),
    .rk_next (rk_next)
  );

  // ShiftRows (row r rotates left by r columns) followed by per-column MixColumns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shifted[127-8*(4*c+r) -: 8] = subbed[127-8*(4*((c+r)%4)+r) -: 8];
    end
    assign mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
  end

  // Final round skips MixColumns.
  assign round_out = ((round_q == 4'(NUM_ROUNDS)) ? shifted : mixed) ^ rk_next;

`ifdef AES_ABORT_EN
  assign in_ready = ready_q & ~abort;
`else
  assign in_ready = ready_q;
`endif

  assign accept   = in_valid & in_ready;
  assign data_out = state_q;

  // Block sequencing: IDLE accept -> ten ROUND cycles -> DONE until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      ready_q   <= 1'b1;
      out_valid <= 1'b0;
      state_q   <= '0;
      rk_q      <= '0;
      rcon_q    <= RCON_INIT;
      round_q   <= 4'd0;
    end
`ifdef AES_ABORT_EN
    else if (abort && (fsm != IDLE)) begin
      fsm       <= IDLE;
      ready_q   <= 1'b1;
      out_valid <= 1'b0;
      state_q   <= '0;
    end
`endif
    else begin
      case (fsm)
        IDLE: begin
          if (accept) begin
            state_q <= data_in ^ key_in;
            rk_q    <= key_in;
            rcon_q  <= RCON_INIT;
            round_q <= 4'd1;
            ready_q <= 1'b0;
            fsm     <= ROUND;
          end
        end
        ROUND: begin
          state_q <= round_out;
          rk_q    <= rk_next;
          rcon_q  <= xtime(rcon_q);
          round_q <= round_q + 4'd1;
          if (round_q == 4'(NUM_ROUNDS)) begin
            fsm       <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
            ready_q   <= 1'b1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_engine.sv
// tb_aes_round_engine: directed + random checks of aes_round_engine against a byte-level AES model.
module tb_aes_round_engine;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R1_B  = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] data_in, key_in, data_out;
`ifdef AES_ABORT_EN
  logic         abort;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] pt, key, outs [2];
  int           waited, acc_t [2], n_acc, n_out;
  bit           acc_pending;

  aes_round_engine dut (
    .clk       (clk),
    .rst       (rst),
`ifdef AES_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  // GF(2^8) multiply with reduction by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // S-box from multiplicative inverse plus affine transform.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  // FIPS-197 cipher on byte arrays; returns the state after 'upto' rounds.
  function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [127:0] k, input int upto);
    logic [7:0]   w [176];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   tmp [4];
    logic [7:0]   rc, x;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      w[i] = k[8*(15-i) +: 8];
      s[i] = p[8*(15-i) +: 8];
    end
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
      if (i % 16 == 0) begin
        x      = tmp[0];
        tmp[0] = sbox_m[tmp[1]] ^ rc;
        tmp[1] = sbox_m[tmp[2]];
        tmp[2] = sbox_m[tmp[3]];
        tmp[3] = sbox_m[x];
        rc     = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
    for (int rnd = 1; rnd <= upto; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rnd < 10)
            s[4*c+r] = gmul(8'h02, t[4*c+r]) ^ gmul(8'h03, t[4*c+(r+1)%4])
                       ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
          else
            s[4*c+r] = t[4*c+r];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd+i];
    end
    for (int i = 0; i < 16; i++) res[8*(15-i) +: 8] = s[i];
    return res;
  endfunction

  task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic start_block(input logic [127:0] p, input logic [127:0] k, output int n_wait);
    in_valid = 1'b1;
    data_in  = p;
    key_in   = k;
    n_wait   = 0;
    while (!in_ready && n_wait < 40) begin
      @(negedge clk);
      n_wait++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    data_in  = rand128();
    key_in   = rand128();
  endtask

  // Follows a block from the negedge after accept to its ciphertext.
  task automatic finish_block(input string tag, input logic [127:0] exp_r0, input logic [127:0] exp_r1,
                              input logic [127:0] exp_ct, input bit consume);
    int cyc;
    cyc = 1;
    check_bit({tag, "_busy_ready"}, in_ready, 1'b0);
    check128({tag, "_r0"}, data_out, exp_r0);
    while (!out_valid && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) check128({tag, "_r1"}, data_out, exp_r1);
    end
    check_int({tag, "_latency"}, cyc, 11);
    check128({tag, "_ct"}, data_out, exp_ct);
    if (consume) begin
      out_ready = 1'b1;
      @(negedge clk);
      check_bit({tag, "_ov_drop"}, out_valid, 1'b0);
      check_bit({tag, "_idle_ready"}, in_ready, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = '0; key_in = '0;
`ifdef AES_ABORT_EN
    abort = 1'b0;
`endif
    build_sbox();
    repeat (3) @(negedge clk);
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check128("rst_data_out", data_out, 128'h0);
    rst = 1'b0;

    // Known-answer vectors, first one accepted on the first edge after reset.
    out_ready = 1'b1;
    start_block(PT_B, KEY_B, waited);
    check_int("app_b_wait", waited, 0);
    finish_block("app_b", PT_B ^ KEY_B, R1_B, CT_B, 1'b1);
    start_block(PT_C, KEY_C, waited);
    finish_block("app_c", PT_C ^ KEY_C, aes_ref(PT_C, KEY_C, 1), CT_C, 1'b1);

    // Random blocks; out_ready level during the rounds must not matter.
    for (int k = 0; k < 6; k++) begin
      pt = rand128();
      key = rand128();
      out_ready = 1'($urandom_range(0, 1));
      start_block(pt, key, waited);
      check_int("rand_wait", waited, 0);
      finish_block("rand", pt ^ key, aes_ref(pt, key, 1), aes_ref(pt, key, 10), 1'b1);
    end

    // Backpressure: output held 20 cycles while in_valid pulses are ignored.
    out_ready = 1'b0;
    pt = rand128();
    key = rand128();
    start_block(pt, key, waited);
    finish_block("bp", pt ^ key, aes_ref(pt, key, 1), aes_ref(pt, key, 10), 1'b0);
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      data_in  = rand128();
      key_in   = rand128();
      @(negedge clk);
      check128("bp_hold_data", data_out, aes_ref(pt, key, 10));
      check_bit("bp_hold_valid", out_valid, 1'b1);
      check_bit("bp_hold_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_bit("bp_release_valid", out_valid, 1'b0);
    check_bit("bp_release_ready", in_ready, 1'b1);
    start_block(PT_C, KEY_C, waited);
    check_int("bp_next_wait", waited, 0);
    finish_block("bp_next", PT_C ^ KEY_C, aes_ref(PT_C, KEY_C, 1), CT_C, 1'b1);

    // Back-to-back with in_valid held high: accepts 12 cycles apart.
    in_valid = 1'b1; data_in = PT_B; key_in = KEY_B;
    n_acc = 0; n_out = 0; acc_pending = 1'b0;
    outs[0] = '0; outs[1] = '0; acc_t[0] = 0; acc_t[1] = 0;
    for (int t = 0; t < 60 && n_out < 2; t++) begin
      if (in_valid && in_ready && n_acc < 2) begin
        acc_t[n_acc] = t;
        n_acc++;
        acc_pending = 1'b1;
      end
      if (out_valid && n_out < 2) begin
        outs[n_out] = data_out;
        n_out++;
      end
      @(negedge clk);
      if (acc_pending) begin
        acc_pending = 1'b0;
        if (n_acc == 1) begin
          data_in = PT_C;
          key_in  = KEY_C;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    check_int("b2b_accepts", n_acc, 2);
    check_int("b2b_spacing", acc_t[1] - acc_t[0], 12);
    check128("b2b_ct0", outs[0], CT_B);
    check128("b2b_ct1", outs[1], CT_C);

    // Asynchronous reset during round 5 clears everything before the next edge.
    start_block(PT_B, KEY_B, waited);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check128("mid_rst_data", data_out, 128'h0);
    check_bit("mid_rst_valid", out_valid, 1'b0);
    check_bit("mid_rst_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    start_block(PT_B, KEY_B, waited);
    check_int("post_rst_wait", waited, 0);
    finish_block("post_rst", PT_B ^ KEY_B, R1_B, CT_B, 1'b1);

`ifdef AES_ABORT_EN
    // Abort during round 3 returns to IDLE with a cleared state and no output.
    start_block(PT_C, KEY_C, waited);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    check128("abort_data", data_out, 128'h0);
    check_bit("abort_valid", out_valid, 1'b0);
    check_bit("abort_ready_gated", in_ready, 1'b0);
    abort = 1'b0;
    #1;
    check_bit("abort_ready", in_ready, 1'b1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_bit("abort_no_valid", out_valid, 1'b0);
    end
    start_block(PT_B, KEY_B, waited);
    finish_block("post_abort", PT_B ^ KEY_B, R1_B, CT_B, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
